// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared definitions for the single-byte I2C master controller:
//   - i2c_state_e : transaction sequencer states
//   - RW_WRITE / RW_READ : encoding of the R/W bit sent after the address
//   - ADDR_BITS / DATA_BITS : slave address and data byte widths
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK1,
    ST_WDATA,
    ST_RDATA,
    ST_ACK2,
    ST_STOP
  } i2c_state_e;

  localparam logic RW_WRITE  = 1'b0;
  localparam logic RW_READ   = 1'b1;

  localparam int   ADDR_BITS = 7;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/i2c_phase_gen.sv
// i2c_phase_gen
// Splits every I2C bit slot into four quarters of CLK_DIV system clocks.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   restart    : synchronous clear of both counters (held while the master idles)
//   q_tick     : last clock of the current quarter
//   pre_tick   : clock just before q_tick, for outputs that must be registered early
//   quarter    : current quarter number 0..3
//   slot_end   : last clock of quarter 3, i.e. the end of a bit slot
module i2c_phase_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  output logic       q_tick,
  output logic       pre_tick,
  output logic [1:0] quarter,
  output logic       slot_end
);

  localparam int DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] div_q;
  logic [1:0]      quarter_q;

  // Divide counter wraps every CLK_DIV clocks and advances the quarter
  // counter; the quarter counter wraps naturally from 3 back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      quarter_q <= '0;
    end else if (restart) begin
      div_q     <= '0;
      quarter_q <= '0;
    end else if (q_tick) begin
      div_q     <= '0;
      quarter_q <= quarter_q + 2'd1;
    end else begin
      div_q     <= div_q + DivW'(1);
    end
  end

  assign q_tick   = (div_q == DivW'(CLK_DIV - 1));
  assign pre_tick = (div_q == DivW'(CLK_DIV - 2));
  assign quarter  = quarter_q;
  assign slot_end = q_tick && (quarter_q == 2'd3);

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl
// Single-byte I2C master: START, address + R/W, ACK, one data byte,
// ACK/NACK, STOP, on behalf of a local requester.
// Ports:
//   clk, rst_n      : system clock, asynchronous active-low reset
//   req, rw         : request strobe (sampled in IDLE) and direction (1 = read)
//   addr, wdata     : slave address and byte to write
//   busy, done      : transaction in flight / one-cycle completion pulse
//   rdata, nack     : byte read (successful reads only) / NACK status of last transfer
//   scl_out         : push-pull SCL, idle high
//   sda_out_s       : open-drain SDA, only ever driven low
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 rw,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 nack,
  output logic                 scl_out,
  inout  wire                  sda_out_s
);

  i2c_state_e          state_q;
  logic [2:0]          bitCnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [DATA_BITS-1:0] rdata_q;
  logic                rw_q;
  logic                ackBit_q;
  logic                nack_q;
  logic                busy_q;
  logic                done_q;

  logic                qTick;
  logic                preTick;
  logic [1:0]          quarter;
  logic                slotEnd;
  logic                sample;
  logic                sdaIn;
  logic                sclLevel;
  logic                sdaOe;

  // Counters are held at zero while idle so the first START quarter
  // starts cleanly on the cycle after a request is accepted.
  i2c_phase_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (state_q == ST_IDLE),
    .q_tick   (qTick),
    .pre_tick (preTick),
    .quarter  (quarter),
    .slot_end (slotEnd)
  );

  assign sdaIn  = sda_out_s;
  assign sample = qTick && (quarter == 2'd2);

  // Transaction sequencer. Slot-level transitions happen on slotEnd; bus
  // samples are taken on the last clock of quarter 2 while SCL is high.
  // The bit counter wraps from 0 back to 7, which re-arms it for the next byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bitCnt_q <= '0;
      shift_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rw_q     <= RW_WRITE;
      ackBit_q <= 1'b0;
      nack_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            shift_q  <= {addr, rw};
            wdata_q  <= wdata;
            rw_q     <= rw;
            nack_q   <= 1'b0;
            busy_q   <= 1'b1;
            bitCnt_q <= 3'(DATA_BITS - 1);
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          if (slotEnd) state_q <= ST_ADDR;
        end
        ST_ADDR, ST_WDATA: begin
          if (slotEnd) begin
            shift_q  <= {shift_q[DATA_BITS-2:0], 1'b0};
            bitCnt_q <= bitCnt_q - 3'd1;
            if (bitCnt_q == 3'd0) state_q <= (state_q == ST_ADDR) ? ST_ACK1 : ST_ACK2;
          end
        end
        ST_ACK1: begin
          if (sample) ackBit_q <= sdaIn;
          if (slotEnd) begin
            if (ackBit_q) begin
              nack_q  <= 1'b1;
              state_q <= ST_STOP;
            end else if (rw_q == RW_READ) begin
              state_q <= ST_RDATA;
            end else begin
              shift_q <= wdata_q;
              state_q <= ST_WDATA;
            end
          end
        end
        ST_RDATA: begin
          if (sample) shift_q <= {shift_q[DATA_BITS-2:0], sdaIn};
          if (slotEnd) begin
            bitCnt_q <= bitCnt_q - 3'd1;
            if (bitCnt_q == 3'd0) state_q <= ST_ACK2;
          end
        end
        ST_ACK2: begin
          if (sample) ackBit_q <= sdaIn;
          if (slotEnd) begin
            if (rw_q == RW_READ) rdata_q <= shift_q;
            else if (ackBit_q)   nack_q  <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Registered one clock early so done lands on the last STOP clock.
          if (preTick && (quarter == 2'd3)) done_q <= 1'b1;
          if (slotEnd) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus levels per state and quarter. In data slots SCL is low for quarters
  // 0-1 and high for 2-3, so SDA only moves while SCL is low; START and STOP
  // deliberately move SDA while SCL is high.
  always_comb begin
    sclLevel = 1'b1;
    sdaOe    = 1'b0;
    case (state_q)
      ST_START: sdaOe = quarter[1];
      ST_ADDR, ST_WDATA: begin
        sclLevel = quarter[1];
        sdaOe    = ~shift_q[DATA_BITS-1];
      end
      ST_ACK1, ST_RDATA, ST_ACK2: sclLevel = quarter[1];
      ST_STOP: begin
        sclLevel = quarter[1];
        sdaOe    = (quarter != 2'd3);
      end
      default: begin
        sclLevel = 1'b1;
        sdaOe    = 1'b0;
      end
    endcase
  end

  assign scl_out   = sclLevel;
  assign sda_out_s = sdaOe ? 1'b0 : 1'bz;

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign nack  = nack_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl
// Directed and randomized transactions against i2c_master_ctrl with a
// behavioural slave on a pulled-up SDA line and a bus monitor counting
// START/STOP conditions and the bits seen on each SCL rising edge.
module tb_i2c_master_ctrl;

  localparam int          CLK_DIV    = 4;
  localparam logic [6:0]  SLAVE_ADDR = 7'h50;
  localparam int          CYC_LIMIT  = 2000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       req   = 1'b0;
  logic       rw    = 1'b0;
  logic [6:0] addr  = '0;
  logic [7:0] wdata = '0;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       nack;
  logic       sclOut;
  wire        sdaBus;

  int assertCnt = 0;
  int failCnt   = 0;

  // Slave model configuration, written only by the stimulus block
  logic [7:0] slaveByte     = '0;
  logic       slaveDataNack = 1'b0;

  // Slave / monitor state, written only by the monitor block
  logic        slaveOe  = 1'b0;
  logic        sclPrev  = 1'b1;
  logic        sdaPrev  = 1'b1;
  logic        slvMatch = 1'b0;
  logic        slvRead  = 1'b0;
  int          startCnt = 0;
  int          stopCnt  = 0;
  int          riseCnt  = 0;
  logic [31:0] bitsSeen = '0;

  logic [7:0] rdataModel = '0;

  pullup (sdaBus);
  assign sdaBus = slaveOe ? 1'b0 : 1'bz;

  i2c_master_ctrl #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rw        (rw),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .nack      (nack),
    .scl_out   (sclOut),
    .sda_out_s (sdaBus)
  );

  always #5 clk = ~clk;

  // Bus monitor and slave, sampled mid-cycle. Detects START/STOP, records
  // every bit on SCL rising edges and changes the slave's SDA drive only
  // right after SCL falls.
  always @(negedge clk) begin
    sclPrev <= sclOut;
    sdaPrev <= sdaBus;
    if (sclOut && sclPrev && sdaPrev && !sdaBus) begin
      startCnt <= startCnt + 1;
      riseCnt  <= 0;
      bitsSeen <= '0;
      slaveOe  <= 1'b0;
    end else if (sclOut && sclPrev && !sdaPrev && sdaBus) begin
      stopCnt  <= stopCnt + 1;
    end else if (sclOut && !sclPrev) begin
      riseCnt  <= riseCnt + 1;
      bitsSeen <= {bitsSeen[30:0], sdaBus};
    end else if (!sclOut && sclPrev) begin
      if (riseCnt == 8) begin
        slvMatch <= (bitsSeen[7:1] == SLAVE_ADDR);
        slvRead  <= bitsSeen[0];
        slaveOe  <= (bitsSeen[7:1] == SLAVE_ADDR);
      end else if (riseCnt >= 9 && riseCnt <= 16) begin
        slaveOe  <= slvMatch && slvRead && !slaveByte[16 - riseCnt];
      end else if (riseCnt == 17) begin
        slaveOe  <= slvMatch && !slvRead && !slaveDataNack;
      end else begin
        slaveOe  <= 1'b0;
      end
    end
  end

  // Single comparison point: counts, and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCnt++;
    assert (obs === exp)
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the DUT to be idle, then presents a request and
  // stops in the first cycle after the accept edge.
  task automatic applyStimulus(input logic [6:0] a, input logic r, input logic [7:0] w, input bit holdReq);
    for (int k = 0; k < 50 && busy !== 1'b0; k++) @(negedge clk);
    @(negedge clk);
    addr  = a;
    rw    = r;
    wdata = w;
    req   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!holdReq) req = 1'b0;
  endtask

  // Counts cycles from the first post-accept cycle (cycle 1) until done,
  // optionally pulsing req for one cycle at cycle pulseAt.
  task automatic waitDone(input int pulseAt, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < CYC_LIMIT) begin
      @(negedge clk);
      cyc++;
      if (pulseAt > 0 && cyc == pulseAt) req = 1'b1;
      else if (pulseAt > 0 && cyc == pulseAt + 1) req = 1'b0;
    end
  endtask

  // Reference model: what the bus and status must look like for one
  // transaction, derived from the protocol rules alone.
  task automatic checkTxn(input string tag, input logic [6:0] a, input logic r, input logic [7:0] w,
                          input int cyc, input int s0, input int p0);
    logic        ack;
    logic [7:0]  dataByte;
    logic        ack2;
    logic [31:0] expBits;
    int          expRises;
    int          expLat;
    logic        expNack;
    ack = (a == SLAVE_ADDR);
    if (ack) begin
      dataByte = r ? slaveByte : w;
      ack2     = r ? 1'b1 : slaveDataNack;
      expBits  = {13'b0, a, r, 1'b0, dataByte, ack2, 1'b0};
      expRises = 19;
      expLat   = 80 * CLK_DIV;
      expNack  = !r && slaveDataNack;
      if (r) rdataModel = slaveByte;
    end else begin
      expBits  = {22'b0, a, r, 1'b1, 1'b0};
      expRises = 10;
      expLat   = 44 * CLK_DIV;
      expNack  = 1'b1;
    end
    checkOutput({tag, "_lat"},   32'(cyc), 32'(expLat));
    checkOutput({tag, "_done"},  32'(done), 32'd1);
    checkOutput({tag, "_busy"},  32'(busy), 32'd1);
    checkOutput({tag, "_nack"},  32'(nack), 32'(expNack));
    checkOutput({tag, "_rdata"}, 32'(rdata), 32'(rdataModel));
    checkOutput({tag, "_bits"},  bitsSeen, expBits);
    checkOutput({tag, "_rises"}, 32'(riseCnt), 32'(expRises));
    checkOutput({tag, "_start"}, 32'(startCnt - s0), 32'd1);
    checkOutput({tag, "_stop"},  32'(stopCnt - p0), 32'd1);
  endtask

  task automatic runTxn(input string tag, input logic [6:0] a, input logic r, input logic [7:0] w,
                        input logic [7:0] sb, input logic dn, input int pulseAt);
    int s0, p0, cyc;
    slaveByte     = sb;
    slaveDataNack = dn;
    s0 = startCnt;
    p0 = stopCnt;
    applyStimulus(a, r, w, 1'b0);
    checkOutput({tag, "_busy1"}, 32'(busy), 32'd1);
    checkOutput({tag, "_nackclr"}, 32'(nack), 32'd0);
    waitDone(pulseAt, cyc);
    checkTxn(tag, a, r, w, cyc, s0, p0);
    @(negedge clk);
    checkOutput({tag, "_donepulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_busyfall"},  32'(busy), 32'd0);
  endtask

  initial begin
    int         s0, p0, cyc;
    logic [6:0] ra;
    logic       rr;
    logic [7:0] rw8;
    logic [7:0] rsb;
    logic       rdn;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_scl",   32'(sclOut), 32'd1);
    checkOutput("rst_sda",   32'(sdaBus), 32'd1);
    checkOutput("rst_busy",  32'(busy),   32'd0);
    checkOutput("rst_done",  32'(done),   32'd0);
    checkOutput("rst_rdata", 32'(rdata),  32'd0);
    checkOutput("rst_nack",  32'(nack),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: ACKed write, read, address NACK, write-data NACK
    runTxn("wr",    7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 0);
    runTxn("rd",    7'h50, 1'b1, 8'h00, 8'h3C, 1'b0, 0);
    runTxn("anak",  7'h22, 1'b1, 8'h00, 8'h99, 1'b0, 0);
    runTxn("dnak",  7'h50, 1'b0, 8'h0F, 8'h00, 1'b1, 0);

    // req pulsed mid-transaction must not start another transaction
    runTxn("pulse", 7'h50, 1'b0, 8'h66, 8'h00, 1'b0, 100);
    s0 = startCnt;
    repeat (6) @(negedge clk);
    checkOutput("pulse_noextra_busy",  32'(busy), 32'd0);
    checkOutput("pulse_noextra_start", 32'(startCnt - s0), 32'd0);

    // req held across done: second transaction accepted after one idle cycle
    slaveByte     = 8'h00;
    slaveDataNack = 1'b0;
    s0 = startCnt;
    p0 = stopCnt;
    applyStimulus(7'h50, 1'b0, 8'h81, 1'b1);
    waitDone(0, cyc);
    checkTxn("b2b1", 7'h50, 1'b0, 8'h81, cyc, s0, p0);
    addr      = 7'h50;
    rw        = 1'b1;
    wdata     = 8'h00;
    slaveByte = 8'hE7;
    @(negedge clk);
    checkOutput("b2b_idle", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("b2b_accept", 32'(busy), 32'd1);
    req = 1'b0;
    s0 = startCnt;
    p0 = stopCnt;
    waitDone(0, cyc);
    checkTxn("b2b2", 7'h50, 1'b1, 8'h00, cyc, s0, p0);
    @(negedge clk);

    // Asynchronous reset in the middle of the write data byte
    applyStimulus(7'h50, 1'b0, 8'h5A, 1'b0);
    repeat (219) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_scl",   32'(sclOut), 32'd1);
    checkOutput("arst_sda",   32'(sdaBus), 32'd1);
    checkOutput("arst_busy",  32'(busy),   32'd0);
    checkOutput("arst_done",  32'(done),   32'd0);
    checkOutput("arst_rdata", 32'(rdata),  32'd0);
    rdataModel = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    runTxn("postrst", 7'h50, 1'b0, 8'hC3, 8'h00, 1'b0, 0);

    // Randomized transactions checked against the reference model
    for (int i = 0; i < 8; i++) begin
      ra  = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom_range(0, 127));
      rr  = 1'($urandom_range(0, 1));
      rw8 = 8'($urandom_range(0, 255));
      rsb = 8'($urandom_range(0, 255));
      rdn = ($urandom_range(0, 3) == 0);
      runTxn($sformatf("rnd%0d", i), ra, rr, rw8, rsb, rdn, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
